// File: rtl/dspi_master.sv
// dspi_master: dual-line SPI initiator (host end), SPI mode 0.
// One transaction asserts ss, writes wr_count bytes, runs DUMMY turnaround
// sclk cycles (only when both a write and a read phase exist), reads rd_count
// bytes, then releases ss. Each sclk carries two bits, MSB pair first, with
// qd[1] holding the higher bit of the pair.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   start                 one-cycle request, ignored while busy
//   wr_count, rd_count    byte counts, latched on an accepted start
//   tx_data/valid/ready   write byte stream; tx_ready marks the accepting cycle
//   rx_data/valid         read byte stream, one-cycle strobe, no backpressure
//   busy, done            transaction in progress / one-cycle end strobe
//   ss, sclk              chip select (active low), SPI clock (idles low)
//   qd_write/qd_writeEnable/qd_read   split-tristate pad pair

module dspi_master #(
   parameter int CLK_DIV  = 2,
   parameter int CS_SETUP = 2,
   parameter int DUMMY    = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] wr_count,
   input  logic [7:0] rd_count,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       ss,
   output logic       sclk,
   output logic [1:0] qd_write,
   output logic [1:0] qd_writeEnable,
   input  logic [1:0] qd_read
);

   localparam int              DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]   DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [15:0]     SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0]     DUMMY_LAST = 16'(DUMMY - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_TURN, S_READ, S_HOLD} state_t;

   state_t          state, post_wr;
   logic [DW-1:0]   div;
   logic [15:0]     cnt;        // SETUP/HOLD clk count, TURN sclk count
   logic [1:0]      pair;       // bit pair within the current byte
   logic [7:0]      wr_left, rd_left;
   logic [7:0]      tx_sh;
   logic [5:0]      rx_sh;
   logic            stall;      // write data underrun: sclk parked low, divider frozen
   logic            run, tick, rise, fall, fetch_first, fetch_next;

   assign run  = (state == S_WRITE) || (state == S_TURN) || (state == S_READ);
   assign tick = (div == DIV_LAST) && !stall;
   assign rise = run && tick && !sclk;
   assign fall = run && tick && sclk;

   // A byte is taken either at the end of SETUP or at the fall closing the
   // previous byte; if it is missing there, the stall waits for it.
   assign fetch_first = (state == S_SETUP) && (cnt == SETUP_LAST) && (wr_left != 8'd0);
   assign fetch_next  = (state == S_WRITE) &&
                        (stall || (fall && (pair == 2'd3) && (wr_left != 8'd1)));
   assign tx_ready    = tx_valid && (fetch_first || fetch_next);

   always_comb begin
      post_wr = S_HOLD;
      if (rd_left != 8'd0) post_wr = (DUMMY > 0) ? S_TURN : S_READ;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         div            <= '0;
         cnt            <= '0;
         pair           <= '0;
         wr_left        <= '0;
         rd_left        <= '0;
         tx_sh          <= '0;
         rx_sh          <= '0;
         stall          <= 1'b0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         ss             <= 1'b1;
         sclk           <= 1'b0;
         qd_write       <= '0;
         qd_writeEnable <= '0;
      end else begin
         done     <= 1'b0;
         rx_valid <= 1'b0;
         div      <= (run && !stall) ? (tick ? '0 : div + 1'b1) : '0;
         case (state)
            S_IDLE: if (start) begin
               wr_left <= wr_count;
               rd_left <= rd_count;
               busy    <= 1'b1;
               ss      <= 1'b0;
               cnt     <= '0;
               pair    <= '0;
               stall   <= 1'b0;
               state   <= S_SETUP;
            end
            S_SETUP: begin
               if (cnt != SETUP_LAST) cnt <= cnt + 16'd1;
               else if (wr_left == 8'd0) begin
                  cnt   <= '0;
                  state <= (rd_left != 8'd0) ? S_READ : S_HOLD;
               end else if (tx_valid) begin
                  tx_sh          <= {tx_data[5:0], 2'b00};
                  qd_write       <= tx_data[7:6];
                  qd_writeEnable <= 2'b11;
                  state          <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (stall) begin
                  if (tx_valid) begin
                     tx_sh    <= {tx_data[5:0], 2'b00};
                     qd_write <= tx_data[7:6];
                     stall    <= 1'b0;
                  end
               end else if (rise) sclk <= 1'b1;
               else if (fall) begin
                  sclk <= 1'b0;
                  pair <= pair + 2'd1;
                  if (pair != 2'd3) begin
                     qd_write <= tx_sh[7:6];
                     tx_sh    <= {tx_sh[5:0], 2'b00};
                  end else if (wr_left == 8'd1) begin
                     qd_writeEnable <= '0;
                     qd_write       <= '0;
                     cnt            <= '0;
                     state          <= post_wr;
                  end else begin
                     wr_left <= wr_left - 8'd1;
                     if (tx_valid) begin
                        tx_sh    <= {tx_data[5:0], 2'b00};
                        qd_write <= tx_data[7:6];
                     end else stall <= 1'b1;
                  end
               end
            end
            S_TURN: begin
               if (rise) sclk <= 1'b1;
               else if (fall) begin
                  sclk <= 1'b0;
                  if (cnt == DUMMY_LAST) begin
                     cnt   <= '0;
                     state <= S_READ;
                  end else cnt <= cnt + 16'd1;
               end
            end
            S_READ: begin
               if (rise) begin
                  sclk  <= 1'b1;
                  rx_sh <= {rx_sh[3:0], qd_read};
                  if (pair == 2'd3) begin
                     rx_data  <= {rx_sh, qd_read};
                     rx_valid <= 1'b1;
                  end
               end else if (fall) begin
                  sclk <= 1'b0;
                  pair <= pair + 2'd1;
                  if (pair == 2'd3) begin
                     if (rd_left == 8'd1) begin
                        cnt   <= '0;
                        state <= S_HOLD;
                     end else rd_left <= rd_left - 8'd1;
                  end
               end
            end
            S_HOLD: begin
               if (cnt == SETUP_LAST) begin
                  ss    <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else cnt <= cnt + 16'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dspi_master.sv
// Bench for dspi_master: directed cases plus randomized transactions. The
// expected behaviour is derived from byte lists (write pairs MSB first, slave
// bytes returned pair by pair after the turnaround) and from transaction
// length arithmetic; bus invariants are tracked every clk.
module tb_dspi_master;
   localparam int CLK_DIV  = 2;
   localparam int CS_SETUP = 2;
   localparam int DUMMY    = 2;

   logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [7:0] wr_count = '0, rd_count = '0, tx_data = '0;
   logic       tx_valid = 1'b0, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, busy, done, ss, sclk;
   logic [1:0] qd_write, qd_writeEnable;
   logic [1:0] qd_read = '0;

   int checks = 0, errors = 0;
   logic [7:0] wq[$], rq[$];

   always #5 clk = ~clk;

   dspi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .DUMMY(DUMMY)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .wr_count(wr_count), .rd_count(rd_count),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .busy(busy), .done(done), .ss(ss), .sclk(sclk),
      .qd_write(qd_write), .qd_writeEnable(qd_writeEnable), .qd_read(qd_read)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Caller enters just after a posedge; returns just after a posedge.
   task automatic run_txn(input int wr, input int rd, input int gap_idx, input int gap_len,
                          input int rst_rise);
      logic [1:0] pairs[$];
      logic [7:0] rxq[$];
      int rises = 0, d_rises = 0, cyc = 0, last_rise = -1000, hi_run = 0, viol = 0;
      int acc_n = 0, done_n = 0, ss_low = 0, ti = 0, gap_cnt = 0, idx;
      int dum = (wr > 0 && rd > 0) ? DUMMY : 0;
      int read_start = 4 * wr + dum;
      logic prev_sclk = 1'b0, d_prev = 1'b0, acc = 1'b0, reset_hit = 1'b0;
      logic [7:0] b;
      start    = 1'b1;
      wr_count = 8'(wr);
      rd_count = 8'(rd);
      tx_valid = (wr > 0);
      tx_data  = (wr > 0) ? wq[0] : 8'h00;
      forever begin
         @(negedge clk);
         acc = tx_valid && tx_ready;
         if (acc) acc_n++;
         if (!prev_sclk && sclk) begin
            if (cyc - last_rise < 2 * CLK_DIV) viol++;
            last_rise = cyc;
            rises++;
            if (qd_writeEnable == 2'b11) pairs.push_back(qd_write);
         end
         hi_run = sclk ? hi_run + 1 : 0;
         if (hi_run > CLK_DIV) viol++;
         if (ss && (sclk || qd_writeEnable != 2'b00)) viol++;
         if (qd_writeEnable != 2'b00 && qd_writeEnable != 2'b11) viol++;
         if (qd_writeEnable != 2'b00 && !sclk && rises >= 4 * wr) viol++;
         if (!ss) ss_low++;
         if (!ss && !busy) viol++;
         if (rx_valid) rxq.push_back(rx_data);
         if (done) begin
            done_n++;
            if (busy || !ss) viol++;
         end
         prev_sclk = sclk;
         cyc++;
         if (done || cyc > 4000) break;
         if (rst_rise >= 0 && rises == rst_rise) begin
            reset_hit = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         start = (cyc == 12);           // must be ignored while busy
         if (start) wr_count = 8'($urandom);
         if (acc) ti++;
         if (ti < wr) begin
            if (ti == gap_idx && gap_cnt < gap_len) begin
               tx_valid = 1'b0;
               gap_cnt++;
            end else begin
               tx_valid = 1'b1;
               tx_data  = wq[ti];
            end
         end else tx_valid = 1'b0;
         // slave: present the next read pair while sclk is low
         if (!d_prev && sclk) d_rises++;
         d_prev = sclk;
         idx = d_rises - read_start;
         if (idx >= 0 && idx < 4 * rd) begin
            b = rq[idx / 4] >> (6 - 2 * (idx % 4));
            qd_read = b[1:0];
         end else qd_read = 2'($urandom);
      end
      start = 1'b0;
      if (reset_hit) begin
         #2 reset_n = 1'b0;
         #1;
         chk("rst_mid_ss", int'(ss), 1);
         chk("rst_mid_oe", int'(qd_writeEnable), 0);
         chk("rst_mid_sclk", int'(sclk), 0);
         chk("rst_mid_busy", int'(busy), 0);
         tx_valid = 1'b0;
         @(negedge clk);
         reset_n = 1'b1;
         repeat (10) begin
            @(negedge clk);
            if (done || rx_valid || !ss || busy) viol++;
         end
         chk("rst_mid_quiet", viol, 0);
         chk("rst_mid_done", done_n, 0);
         chk("rst_mid_rx", rxq.size(), 0);
      end else begin
         chk("done_cnt", done_n, 1);
         chk("tx_ready_cnt", acc_n, wr);
         chk("sclk_rises", rises, 4 * (wr + rd) + dum);
         chk("wr_pairs", pairs.size(), 4 * wr);
         for (int i = 0; i < wr && 4 * i + 3 < pairs.size(); i++)
            chk($sformatf("wr_byte%0d", i), int'({pairs[4*i], pairs[4*i+1], pairs[4*i+2], pairs[4*i+3]}),
                int'(wq[i]));
         chk("rx_cnt", rxq.size(), rd);
         for (int i = 0; i < rd && i < rxq.size(); i++)
            chk($sformatf("rx_byte%0d", i), int'(rxq[i]), int'(rq[i]));
         chk("bus_viol", viol, 0);
         if (gap_len == 0)
            chk("ss_low_clks", ss_low, 2 * CS_SETUP + CLK_DIV * (8 * (wr + rd) + 2 * dum));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int viol;
      int wr, rd, gi, gl;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ss", int'(ss), 1);
      chk("rst_sclk", int'(sclk), 0);
      chk("rst_oe", int'(qd_writeEnable), 0);
      chk("rst_qdw", int'(qd_write), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_txready", int'(tx_ready), 0);
      chk("rst_rxvalid", int'(rx_valid), 0);
      chk("rst_rxdata", int'(rx_data), 0);
      @(negedge clk);
      reset_n = 1'b1;
      viol = 0;
      repeat (100) begin
         @(negedge clk);
         if (!ss || sclk || qd_writeEnable != 2'b00 || busy || done) viol++;
      end
      chk("idle_100", viol, 0);
      @(posedge clk);
      #1;

      // two-byte write, no read
      wq = {8'hA5, 8'h3C}; rq = {};
      run_txn(2, 0, -1, 0, -1);
      // one write, turnaround, two reads
      wq = {8'h9F}; rq = {8'hC3, 8'h01};
      run_txn(1, 2, -1, 0, -1);
      // write with a 20-clk underrun before byte 2
      wq = {8'hA5, 8'h3C}; rq = {};
      run_txn(2, 0, 1, 20, -1);
      // empty transaction
      wq = {}; rq = {};
      run_txn(0, 0, -1, 0, -1);
      // reset in the middle of byte 2 of a 4-byte write, then a normal run
      wq = {8'h12, 8'h34, 8'h56, 8'h78};
      run_txn(4, 0, -1, 0, 6);
      rq = {8'hE7};
      run_txn(4, 1, -1, 0, -1);

      // randomized transactions
      for (int t = 0; t < 14; t++) begin
         wr = $urandom_range(0, 3);
         rd = $urandom_range(0, 3);
         wq = {}; rq = {};
         for (int i = 0; i < wr; i++) wq.push_back(8'($urandom));
         for (int i = 0; i < rd; i++) rq.push_back(8'($urandom));
         gi = (wr > 1) ? $urandom_range(1, wr - 1) : -1;
         gl = (gi > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
         run_txn(wr, rd, gi, gl, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
